// File: rtl/enc16to4_scan_if.sv
//------------------------------------------------------------------------------
// Module  : enc16to4_scan_if
// Brief   : Request-vector capture and index-stream bundle for enc16to4_scan.
//           ENC_POPCOUNT_EN adds the cnt signal.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface enc16to4_scan_if;
   logic [15:0] in_vec;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  idx;
   logic        idx_valid;
   logic        idx_ready;
   logic        idx_last;
   logic        zero;
`ifdef ENC_POPCOUNT_EN
   logic [4:0]  cnt;

   modport master (
      output in_vec, in_valid, idx_ready,
      input  in_ready, idx, idx_valid, idx_last, zero, cnt
   );

   modport slave (
      input  in_vec, in_valid, idx_ready,
      output in_ready, idx, idx_valid, idx_last, zero, cnt
   );
`else
   modport master (
      output in_vec, in_valid, idx_ready,
      input  in_ready, idx, idx_valid, idx_last, zero
   );

   modport slave (
      input  in_vec, in_valid, idx_ready,
      output in_ready, idx, idx_valid, idx_last, zero
   );
`endif
endinterface

`default_nettype wire

// File: rtl/enc16to4_scan.sv
//------------------------------------------------------------------------------
// Module  : enc16to4_scan
// Brief   : Sequential 16-to-4 encoder; emits the index of every set request bit
//           one per transfer in priority order. ENC_POPCOUNT_EN adds cnt.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module enc16to4_scan #(
   parameter int N         = 16,
   parameter bit LSB_FIRST = 1'b1
) (
   input  wire             clk,
   input  wire             rst,
   enc16to4_scan_if.slave  bus
);

   localparam logic [0:0] c_idle = 1'b0;
   localparam logic [0:0] c_emit = 1'b1;

   logic [0:0]   r_state;
   logic [0:0]   w_state_nxt;
   logic [N-1:0] r_pend;
   logic [N-1:0] w_pend_nxt;
   logic         r_zero;
   logic [3:0]   w_idx;
   logic         w_single;
   logic         w_accept;

   assign w_accept = (r_state == c_idle) && bus.in_valid;

   // Later matches overwrite earlier ones, so the scan direction sets priority.
   always_comb begin
      w_idx = '0;
      if (LSB_FIRST) begin
         for (int i = N - 1; i >= 0; i--) begin
            if (r_pend[i]) w_idx = 4'(i);
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (r_pend[i]) w_idx = 4'(i);
         end
      end
   end

   assign w_single = (r_pend != '0) && ((r_pend & (r_pend - 1'b1)) == '0);

`ifdef ENC_POPCOUNT_EN
   logic [4:0] r_cnt;

   function automatic logic [4:0] popcnt(input logic [N-1:0] v);
      logic [4:0] s;
      s = '0;
      for (int i = 0; i < N; i++) s = s + 5'(v[i]);
      return s;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           r_cnt <= '0;
      else if (w_accept) r_cnt <= popcnt(bus.in_vec);
   end

   assign bus.cnt = r_cnt;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_idle;
         r_pend  <= '0;
         r_zero  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pend  <= w_pend_nxt;
         r_zero  <= w_accept && (bus.in_vec == '0);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pend_nxt  = r_pend;
      case (r_state)
         c_idle: begin
            if (w_accept && (bus.in_vec != '0)) begin
               w_pend_nxt  = bus.in_vec;
               w_state_nxt = c_emit;
            end
         end
         c_emit: begin
            if (bus.idx_ready) begin
               w_pend_nxt = r_pend & ~(N'(1) << w_idx);
               if (w_single) w_state_nxt = c_idle;
            end
         end
         default: w_state_nxt = c_idle;
      endcase
   end

   always_comb begin
      bus.in_ready  = (r_state == c_idle);
      bus.idx_valid = (r_state == c_emit);
      bus.idx       = w_idx;
      bus.idx_last  = (r_state == c_emit) && w_single;
      bus.zero      = r_zero;
   end

endmodule

`default_nettype wire
